// File: rtl/wb_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : wb_pipe
//  Description : EX/MEM and MEM/WB write-back pipeline stages with
//                stall/flush control, EX/MEM/WB-to-decode operand
//                forwarding and a count of committed register writes.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_pipe #(
  parameter int FWD_EN = 1
) (
  input  logic        clk,
  input  logic        rst,

  // Result leaving the EX stage
  input  logic [4:0]  ex_wd_i,
  input  logic        ex_wreg_i,
  input  logic [31:0] ex_wdata_i,

  // Pipeline control
  input  logic [1:0]  stall_i,
  input  logic        flush_i,

  // Decode read ports looking for forwarded operands
  input  logic        rd1_en_i,
  input  logic [4:0]  rd1_addr_i,
  input  logic        rd2_en_i,
  input  logic [4:0]  rd2_addr_i,

  // Register-file write port
  output logic        wb_we_o,
  output logic [4:0]  wb_waddr_o,
  output logic [31:0] wb_wdata_o,

  // Forwarded operands
  output logic        fwd1_hit_o,
  output logic [31:0] fwd1_data_o,
  output logic        fwd2_hit_o,
  output logic [31:0] fwd2_data_o,

  // Committed-write counter
  output logic [31:0] retire_cnt_o
);

  // --------------------------------------------------------------------------
  // Stage update action, decoded once from flush/stall and shared by both
  // stages so their behaviour can never disagree.
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    OP_ADVANCE = 2'd0,  // em <= ex, mw <= em
    OP_BUBBLE  = 2'd1,  // em held, mw <= bubble
    OP_HOLD    = 2'd2,  // both held
    OP_CLEAR   = 2'd3   // both loaded with bubbles
  } stage_op_e;

  stage_op_e op_w;

  // EX/MEM stage
  logic        em_we_q,    em_we_d;
  logic [4:0]  em_waddr_q, em_waddr_d;
  logic [31:0] em_wdata_q, em_wdata_d;

  // MEM/WB stage
  logic        mw_we_q,    mw_we_d;
  logic [4:0]  mw_waddr_q, mw_waddr_d;
  logic [31:0] mw_wdata_q, mw_wdata_d;

  // Commit counter
  logic [31:0] retire_cnt_q, retire_cnt_d;

  // Entry coming from EX, with writes to register 0 neutralised on entry
  logic        ex_we_w;

  // Flush outranks any stall; stall bit1 freezes the whole block.
  always_comb begin
    op_w = OP_ADVANCE;
    if (flush_i) begin
      op_w = OP_CLEAR;
    end else if (stall_i[1]) begin
      op_w = OP_HOLD;
    end else if (stall_i[0]) begin
      op_w = OP_BUBBLE;
    end
  end

  assign ex_we_w = ex_wreg_i && (ex_wd_i != 5'd0);

  // Next-state for both stages from the decoded action.
  always_comb begin
    em_we_d    = em_we_q;
    em_waddr_d = em_waddr_q;
    em_wdata_d = em_wdata_q;
    mw_we_d    = mw_we_q;
    mw_waddr_d = mw_waddr_q;
    mw_wdata_d = mw_wdata_q;
    case (op_w)
      OP_ADVANCE: begin
        em_we_d    = ex_we_w;
        em_waddr_d = ex_wd_i;
        em_wdata_d = ex_wdata_i;
        mw_we_d    = em_we_q;
        mw_waddr_d = em_waddr_q;
        mw_wdata_d = em_wdata_q;
      end
      OP_BUBBLE: begin
        mw_we_d    = 1'b0;
        mw_waddr_d = 5'd0;
        mw_wdata_d = 32'd0;
      end
      OP_HOLD: begin
        // keep both stages as they are
      end
      OP_CLEAR: begin
        em_we_d    = 1'b0;
        em_waddr_d = 5'd0;
        em_wdata_d = 32'd0;
        mw_we_d    = 1'b0;
        mw_waddr_d = 5'd0;
        mw_wdata_d = 32'd0;
      end
      default: begin
        em_we_d    = 1'b0;
        em_waddr_d = 5'd0;
        em_wdata_d = 32'd0;
        mw_we_d    = 1'b0;
        mw_waddr_d = 5'd0;
        mw_wdata_d = 32'd0;
      end
    endcase
  end

  // A write in MEM/WB commits once; while the block is frozen the same
  // write is presented again and must not be counted again. Wraps freely.
  always_comb begin
    retire_cnt_d = retire_cnt_q;
    if (mw_we_q && !stall_i[1]) begin
      retire_cnt_d = retire_cnt_q + 32'd1;
    end
  end

  // Stage and counter registers; reset outranks flush and stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      em_we_q      <= 1'b0;
      em_waddr_q   <= 5'd0;
      em_wdata_q   <= 32'd0;
      mw_we_q      <= 1'b0;
      mw_waddr_q   <= 5'd0;
      mw_wdata_q   <= 32'd0;
      retire_cnt_q <= 32'd0;
    end else begin
      em_we_q      <= em_we_d;
      em_waddr_q   <= em_waddr_d;
      em_wdata_q   <= em_wdata_d;
      mw_we_q      <= mw_we_d;
      mw_waddr_q   <= mw_waddr_d;
      mw_wdata_q   <= mw_wdata_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  // Register-file port comes straight from flops.
  assign wb_we_o      = mw_we_q;
  assign wb_waddr_o   = mw_waddr_q;
  assign wb_wdata_o   = mw_wdata_q;
  assign retire_cnt_o = retire_cnt_q;

  // --------------------------------------------------------------------------
  // Forwarding. Both read ports share one lookup structure; the youngest
  // producer wins (EX input, then EX/MEM, then MEM/WB). Stage contents are
  // used as registered, regardless of this cycle's stall or flush.
  // --------------------------------------------------------------------------
  logic        rd_en_w   [2];
  logic [4:0]  rd_addr_w [2];
  logic        fwd_hit_w [2];
  logic [31:0] fwd_data_w[2];

  assign rd_en_w[0]   = rd1_en_i;
  assign rd_en_w[1]   = rd2_en_i;
  assign rd_addr_w[0] = rd1_addr_i;
  assign rd_addr_w[1] = rd2_addr_i;

  for (genvar p = 0; p < 2; p++) begin : g_port
    if (FWD_EN != 0) begin : g_fwd_on
      logic ex_match_w;
      logic em_match_w;
      logic mw_match_w;

      assign ex_match_w = ex_wreg_i && (ex_wd_i    == rd_addr_w[p]);
      assign em_match_w = em_we_q   && (em_waddr_q == rd_addr_w[p]);
      assign mw_match_w = mw_we_q   && (mw_waddr_q == rd_addr_w[p]);

      // Priority select of the youngest matching producer.
      always_comb begin
        fwd_hit_w[p]  = 1'b0;
        fwd_data_w[p] = 32'd0;
        if (rd_en_w[p] && (rd_addr_w[p] != 5'd0)) begin
          if (ex_match_w) begin
            fwd_hit_w[p]  = 1'b1;
            fwd_data_w[p] = ex_wdata_i;
          end else if (em_match_w) begin
            fwd_hit_w[p]  = 1'b1;
            fwd_data_w[p] = em_wdata_q;
          end else if (mw_match_w) begin
            fwd_hit_w[p]  = 1'b1;
            fwd_data_w[p] = mw_wdata_q;
          end
        end
      end
    end else begin : g_fwd_off
      assign fwd_hit_w[p]  = 1'b0;
      assign fwd_data_w[p] = 32'd0;
    end
  end

  assign fwd1_hit_o  = fwd_hit_w[0];
  assign fwd1_data_o = fwd_data_w[0];
  assign fwd2_hit_o  = fwd_hit_w[1];
  assign fwd2_data_o = fwd_data_w[1];

endmodule
`default_nettype wire

// File: tb/tb_wb_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_pipe
//  Description : Self-checking bench for wb_pipe: directed scenarios followed
//                by randomized traffic against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata;
  logic [1:0]  stall;
  logic        flush;
  logic        rd1_en, rd2_en;
  logic [4:0]  rd1_addr, rd2_addr;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        fwd1_hit, fwd2_hit;
  logic [31:0] fwd1_data, fwd2_data;
  logic [31:0] retire_cnt;

  always #5 clk = ~clk;

  wb_pipe #(.FWD_EN(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .ex_wd_i      (ex_wd),
    .ex_wreg_i    (ex_wreg),
    .ex_wdata_i   (ex_wdata),
    .stall_i      (stall),
    .flush_i      (flush),
    .rd1_en_i     (rd1_en),
    .rd1_addr_i   (rd1_addr),
    .rd2_en_i     (rd2_en),
    .rd2_addr_i   (rd2_addr),
    .wb_we_o      (wb_we),
    .wb_waddr_o   (wb_waddr),
    .wb_wdata_o   (wb_wdata),
    .fwd1_hit_o   (fwd1_hit),
    .fwd1_data_o  (fwd1_data),
    .fwd2_hit_o   (fwd2_hit),
    .fwd2_data_o  (fwd2_data),
    .retire_cnt_o (retire_cnt)
  );

  // Behavioural model: two pipeline slots plus a commit count.
  typedef struct packed {
    logic        we;
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t        m_em, m_mw;
  logic [31:0] m_cnt;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Youngest-first search over {EX input, EX/MEM, MEM/WB}.
  function automatic void m_fwd(input logic en, input logic [4:0] addr,
                                output logic hit, output logic [31:0] data);
    ent_t cand[3];
    cand[0] = {ex_wreg, ex_wd, ex_wdata};
    cand[1] = m_em;
    cand[2] = m_mw;
    hit  = 1'b0;
    data = 32'd0;
    for (int i = 0; i < 3; i++) begin
      if (!hit && en && addr != 5'd0 && cand[i].we && cand[i].a == addr) begin
        hit  = 1'b1;
        data = cand[i].d;
      end
    end
  endfunction

  task automatic check_all();
    logic        h1, h2;
    logic [31:0] d1, d2;
    m_fwd(rd1_en, rd1_addr, h1, d1);
    m_fwd(rd2_en, rd2_addr, h2, d2);
    chk("wb_we",    {31'd0, wb_we},    {31'd0, m_mw.we});
    chk("wb_waddr", {27'd0, wb_waddr}, {27'd0, m_mw.a});
    chk("wb_wdata", wb_wdata,          m_mw.d);
    chk("retire",   retire_cnt,        m_cnt);
    chk("fwd1_hit", {31'd0, fwd1_hit}, {31'd0, h1});
    chk("fwd1_data", fwd1_data,        d1);
    chk("fwd2_hit", {31'd0, fwd2_hit}, {31'd0, h2});
    chk("fwd2_data", fwd2_data,        d2);
  endtask

  // Apply one clock edge to the model using the inputs held at the edge.
  task automatic m_step();
    ent_t ex_e;
    ex_e = {ex_wreg && (ex_wd != 5'd0), ex_wd, ex_wdata};
    if (rst) begin
      m_em  = '0;
      m_mw  = '0;
      m_cnt = 32'd0;
    end else begin
      if (m_mw.we && !stall[1]) m_cnt = m_cnt + 32'd1;
      if (flush) begin
        m_em = '0;
        m_mw = '0;
      end else if (stall[1]) begin
        m_em = m_em;
      end else if (stall[0]) begin
        m_mw = '0;
      end else begin
        m_mw = m_em;
        m_em = ex_e;
      end
    end
  endtask

  // Inputs are set at the falling edge; check, clock, land on next falling edge.
  task automatic cyc();
    #1 check_all();
    @(posedge clk);
    m_step();
    @(negedge clk);
  endtask

  task automatic set_ex(input logic we, input logic [4:0] a, input logic [31:0] d);
    ex_wreg  = we;
    ex_wd    = a;
    ex_wdata = d;
  endtask

  task automatic set_rd(input logic e1, input logic [4:0] a1, input logic e2, input logic [4:0] a2);
    rd1_en   = e1;
    rd1_addr = a1;
    rd2_en   = e2;
    rd2_addr = a2;
  endtask

  initial begin
    // Reset asserted together with stall and flush; reset must win.
    rst = 1'b1;
    stall = 2'b11;
    flush = 1'b1;
    set_ex(1'b1, 5'd3, 32'hDEAD_BEEF);
    set_rd(1'b1, 5'd3, 1'b1, 5'd4);
    m_em = '0; m_mw = '0; m_cnt = 32'd0;
    @(posedge clk);
    @(negedge clk);
    cyc();
    chk("reset_we",  {31'd0, wb_we}, 32'd0);
    chk("reset_cnt", retire_cnt,     32'd0);
    chk("reset_data", wb_wdata,      32'd0);

    // Streaming three writes
    rst = 1'b0; stall = 2'b00; flush = 1'b0;
    set_rd(1'b0, 5'd0, 1'b0, 5'd0);
    set_ex(1'b1, 5'd5, 32'h11); cyc();
    set_ex(1'b1, 5'd6, 32'h22); cyc();
    set_ex(1'b1, 5'd7, 32'h33); cyc();
    set_ex(1'b0, 5'd0, 32'h0);  cyc();
    chk("stream_r7_addr", {27'd0, wb_waddr}, 32'd7);
    chk("stream_r7_data", wb_wdata,          32'h33);
    cyc();
    chk("stream_cnt", retire_cnt, 32'd3);

    // Forward priority EX > EX/MEM > MEM/WB
    set_ex(1'b1, 5'd4, 32'hB); cyc();
    set_ex(1'b1, 5'd4, 32'hA); cyc();
    set_ex(1'b1, 5'd4, 32'hC);
    set_rd(1'b1, 5'd4, 1'b1, 5'd4);
    #1 chk("fwd_prio_ex_hit", {31'd0, fwd1_hit}, 32'd1);
    chk("fwd_prio_ex_data", fwd1_data, 32'hC);
    ex_wreg = 1'b0;
    #1 chk("fwd_prio_em_data", fwd1_data, 32'hA);
    chk("fwd_prio_em_port2", fwd2_data, 32'hA);
    cyc();
    set_rd(1'b0, 5'd0, 1'b0, 5'd0);

    // Stall 01 for two cycles with r9 sitting in EX/MEM
    set_ex(1'b1, 5'd9, 32'h99); cyc();
    set_ex(1'b0, 5'd0, 32'h0);
    stall = 2'b01;
    cyc();
    chk("stall_bubble_we", {31'd0, wb_we}, 32'd0);
    cyc();
    chk("stall_bubble_we2", {31'd0, wb_we}, 32'd0);
    stall = 2'b00;
    cyc();
    chk("stall_release_addr", {27'd0, wb_waddr}, 32'd9);
    chk("stall_release_data", wb_wdata,          32'h99);
    cyc();
    chk("stall_release_once", {31'd0, wb_we}, 32'd0);

    // Flush with both stages valid, then flush combined with stall 11
    for (int k = 0; k < 2; k++) begin
      set_ex(1'b1, 5'd10, 32'hAA); cyc();
      set_ex(1'b1, 5'd11, 32'hBB); cyc();
      set_ex(1'b0, 5'd0, 32'h0);
      flush = 1'b1;
      stall = (k == 0) ? 2'b00 : 2'b11;
      cyc();
      flush = 1'b0;
      stall = 2'b00;
      set_rd(1'b1, 5'd10, 1'b1, 5'd11);
      #1 chk("flush_we",   {31'd0, wb_we},    32'd0);
      chk("flush_fwd1",    {31'd0, fwd1_hit}, 32'd0);
      chk("flush_fwd2",    {31'd0, fwd2_hit}, 32'd0);
      cyc();
    end

    // Register 0 writes never commit and never forward
    set_rd(1'b1, 5'd0, 1'b0, 5'd0);
    set_ex(1'b1, 5'd0, 32'hFFFF);
    for (int k = 0; k < 3; k++) begin
      #1 chk("r0_fwd_hit",  {31'd0, fwd1_hit}, 32'd0);
      chk("r0_fwd_data",    fwd1_data,         32'd0);
      chk("r0_wb_we",       {31'd0, wb_we},    32'd0);
      cyc();
    end
    chk("r0_wb_we_end", {31'd0, wb_we}, 32'd0);

    // Counter wrap: preload the counter and commit one write
    set_rd(1'b0, 5'd0, 1'b0, 5'd0);
    set_ex(1'b1, 5'd3, 32'h3333); cyc();
    set_ex(1'b0, 5'd0, 32'h0);    cyc();
    force dut.retire_cnt_q = 32'hFFFF_FFFF;
    #1 release dut.retire_cnt_q;
    m_cnt = 32'hFFFF_FFFF;
    cyc();
    chk("wrap_cnt", retire_cnt, 32'd0);

    // Reset in the middle of a stream
    set_ex(1'b1, 5'd12, 32'h1212); cyc();
    set_ex(1'b1, 5'd13, 32'h1313); cyc();
    set_ex(1'b1, 5'd14, 32'h1414);
    rst = 1'b1;
    cyc();
    chk("midrst_we",   {31'd0, wb_we},    32'd0);
    chk("midrst_addr", {27'd0, wb_waddr}, 32'd0);
    chk("midrst_data", wb_wdata,          32'd0);
    chk("midrst_cnt",  retire_cnt,        32'd0);
    rst = 1'b0;

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      set_ex(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom);
      set_rd(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)));
      stall = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      flush = ($urandom_range(0, 15) == 0);
      rst   = ($urandom_range(0, 60) == 0);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_pipe.md
WB_PIPE -- requirements
Module: wb_pipe

Interface
REQ-001 Parameter FWD_EN, default 1: 1 enables the forwarding outputs; 0 forces fwd1_hit_o, fwd2_hit_o and both fwd data outputs to 0.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 ex_wd_i  input  5  destination register address of the EX result.
REQ-005 ex_wreg_i  input  1  EX result write enable.
REQ-006 ex_wdata_i  input  32  EX result data.
REQ-007 stall_i  input  2  bit0 holds the EX/MEM stage; bit1 holds the MEM/WB stage.
REQ-008 flush_i  input  1  discards both stages.
REQ-009 rd1_en_i, rd2_en_i  input  1 each  decode read-port enables.
REQ-010 rd1_addr_i, rd2_addr_i  input  5 each  decode read-port addresses.
REQ-011 wb_we_o  output  1  register-file write enable.
REQ-012 wb_waddr_o  output  5  register-file write address.
REQ-013 wb_wdata_o  output  32  register-file write data.
REQ-014 fwd1_hit_o, fwd2_hit_o  output  1 each  forwarded value valid for port 1 / port 2.
REQ-015 fwd1_data_o, fwd2_data_o  output  32 each  forwarded value for port 1 / port 2.
REQ-016 retire_cnt_o  output  32  count of committed register writes.

Function
REQ-017 The block SHALL hold two registered stages, EX/MEM (em_*) and MEM/WB (mw_*), each containing we, waddr and wdata.
REQ-018 With stall_i=00 and flush_i=0, each edge SHALL load em from ex_* and mw from em.
- Latency: an EX result presented in cycle N appears on wb_* after edge N+2.
REQ-019 wb_we_o/wb_waddr_o/wb_wdata_o SHALL be driven directly from mw_* registers, with no combinational path from inputs.
REQ-020 stall_i=01 SHALL hold em and load mw with a bubble (we=0, waddr=0, wdata=0).
REQ-021 stall_i=11 or stall_i=10 SHALL hold both em and mw (bit1 implies hold of the whole block).
REQ-022 flush_i=1 SHALL load bubbles into em and mw on the next edge; flush_i has priority over stall_i, and rst has priority over flush_i.
REQ-023 A stage entry with waddr=0 SHALL be stored with we forced to 0.
- Register 0 is never written.
REQ-024 Forwarding for port k SHALL be combinational, with priority EX input (ex_wreg_i) > em > mw; hit requires rdk_en_i=1, a matching address, the stage's we=1, and rdk_addr_i!=0.
REQ-025 On no hit, fwdk_hit_o SHALL be 0 and fwdk_data_o SHALL be 0.
REQ-026 Forwarding SHALL ignore stall and flush for the current cycle.
- Stage contents are used as currently registered.
REQ-027 retire_cnt_o SHALL increment by 1 on each edge where mw.we=1 and stall_i[1]=0, so a held write counts once.
REQ-028 retire_cnt_o SHALL wrap from 0xFFFF_FFFF to 0x0000_0000.
REQ-029 The same-address write in em and mw simultaneously SHALL forward the em value (younger wins).

Reset
REQ-030 rst=1 at an edge SHALL clear em, mw and retire_cnt_o to 0, giving wb_we_o=0, wb_waddr_o=0, wb_wdata_o=0 and retire_cnt_o=0.
REQ-031 Reset asserted mid-stall or mid-flush SHALL override both.
- The cycle after rst deasserts operates normally from the all-bubble state.
REQ-032 Forward outputs SHALL follow REQ-024 during reset.
- Stages read as bubbles after the first reset edge.

Verification
REQ-033 Streaming: ex writes r5=0x11, r6=0x22, r7=0x33 on cycles 1-3 -> wb shows r5/0x11 after edge 3, r6/0x22 after edge 4, r7/0x33 after edge 5; retire_cnt_o reaches 3.
REQ-034 Forward priority: em holds r4=0xA, mw holds r4=0xB, ex drives r4=0xC, rd1 reads r4 -> fwd1 hit, data 0xC; drop ex_wreg_i -> data 0xA.
REQ-035 Stall 01 for two cycles with em=r9/0x99 -> em holds, wb_we_o=0 during the stall, r9/0x99 is written once after release, retire_cnt_o +1.
REQ-036 Flush while both stages are valid -> next cycle wb_we_o=0 and fwd hits=0; flush with stall=11 still clears.
REQ-037 Register 0: ex writes r0=0xFFFF -> wb_we_o never 1, rd1 on r0 -> hit=0, data 0.
REQ-038 Counter wrap: preload via 2^32-1 writes or force -> next commit gives retire_cnt_o=0; rst mid-stream -> all outputs 0 after the edge.
